// File: rtl/seq_pattern_detect.sv
// Serial bit-pattern detector: programmable N-bit pattern with per-bit don't-care mask,
// overlapping or non-overlapping detection, registered match pulse and saturating counter.
module seq_pattern_detect #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [N-1:0]     cfg_pattern,
    input  logic [N-1:0]     cfg_mask,
    input  logic             cfg_overlap,
    input  logic             x_valid,
    input  logic             x,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int                FW      = $clog2(N + 1);
    localparam logic [FW-1:0]     FULL    = FW'(N);
    localparam logic [31:0]       DEF_PAT = 32'h0000_000B;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [N-1:0]     sh_q,    sh_d;
    logic [FW-1:0]    fill_q,  fill_d;
    logic [N-1:0]     pat_q,   pat_d;
    logic [N-1:0]     mask_q,  mask_d;
    logic             ovl_q,   ovl_d;
    logic             y_q,     y_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             armed_q, armed_d;

    logic [N-1:0]     sh_shift_s;
    logic [FW-1:0]    fill_inc_s;
    logic             match_s;

    // Next-state logic: the match is judged on the history as it will look after this edge
    always_comb begin
        sh_shift_s = {sh_q[N-2:0], x};
        fill_inc_s = (fill_q == FULL) ? FULL : (fill_q + FW'(1));
        match_s    = x_valid & ~cfg_load & (((sh_shift_s ^ pat_q) & mask_q) == '0)
                     & (fill_inc_s == FULL);

        sh_d   = sh_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        mask_d = mask_q;
        ovl_d  = ovl_q;

        if (cfg_load) begin
            pat_d  = cfg_pattern;
            mask_d = cfg_mask;
            ovl_d  = cfg_overlap;
            sh_d   = '0;
            fill_d = '0;
        end else if (x_valid) begin
            sh_d   = sh_shift_s;
            // Non-overlap restarts the fill so the next match needs N fresh bits
            fill_d = (match_s & ~ovl_q) ? '0 : fill_inc_s;
        end else begin
            sh_d   = sh_q;
            fill_d = fill_q;
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        y_d     = match_s;
        armed_d = (fill_d == FULL);
    end

    // State registers with synchronous reset to the legacy 1011 detector configuration
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q    <= '0;
            fill_q  <= '0;
            pat_q   <= DEF_PAT[N-1:0];
            mask_q  <= '1;
            ovl_q   <= 1'b1;
            y_q     <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            ovl_q   <= ovl_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign y           = y_q;
    assign match_count = cnt_q;
    assign armed       = armed_q;

endmodule
